ppm16_rx_ctrl: RTL
==================

# ppm16_rx_ctrl

Receive-session controller sitting between the system and `ppm16_demod`. It drives the demodulator's reset, `rx_start` and correlation threshold, retries the packet search on timeout while stepping the threshold down, and packs the demodulated 4-bit symbols into bytes. Bytes leave on a valid/ready stream. A `pkt_done` pulse and status flags mark the end of each session.

## Interface
- `CHIP_BITS`, 2: width of the demod correlation threshold.
- `TIMEOUT_BITS`, 16: width of the search-timeout counter and its config.
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high; dominates all other inputs.
- `enable`  in  1  level; high = run sessions back-to-back, low = abort and idle.
- `cfg_threshold`  in  CHIP_BITS  initial correlation threshold.
- `cfg_min_threshold`  in  CHIP_BITS  floor for threshold stepping.
- `cfg_search_timeout`  in  TIMEOUT_BITS  search cycles per attempt; 0 = no timeout.
- `cfg_max_retries`  in  4  retries allowed after the first attempt.
- `demod_resetn`  out  1  to demod `resetn` (active-low).
- `demod_rx_start`  out  1  one-cycle start pulse to demod.
- `demod_corr_threshold`  out  CHIP_BITS  to demod `corr_threshold_ext`.
- `demod_packet_detected`  in  1  from demod.
- `demod_dout_valid`  in  1  from demod.
- `demod_dout`  in  4  from demod.
- `byte_valid` / `byte_data`  out  1 / 8  output byte stream.
- `byte_ready`  in  1  consumer accepts when valid && ready.
- `busy`  out  1  high in any state other than IDLE.
- `pkt_done`  out  1  one-cycle pulse at session end.
- `timeout_err`, `overflow_err`, `odd_nibble`  out  1 each  sticky status; cleared on the next IDLE→RST_DEMOD transition.

## Operation
- States: IDLE, RST_DEMOD, ARM, SEARCH, RECEIVE, FLUSH, DONE.
- IDLE
  - `demod_resetn`=0.
  - When `enable`=1: load the threshold register from `cfg_threshold`, clear the retry counter and status flags, go to RST_DEMOD.
- RST_DEMOD: `demod_resetn`=0 for exactly RESET_CYCLES=2 cycles, then ARM.
- ARM: `demod_rx_start`=1 for one cycle, then SEARCH. The search timer clears here.
- SEARCH
  - Timer increments each cycle.
  - `demod_packet_detected`=1 → RECEIVE. Detection wins over a same-cycle timeout.
  - Timeout occurs when timer == `cfg_search_timeout` and the config is ≠ 0.
    - If retries < `cfg_max_retries`: retries += 1; threshold -= 1, saturating at `cfg_min_threshold`; go to RST_DEMOD.
    - Otherwise set `timeout_err` and go to DONE.
- RECEIVE
  - Each `demod_dout_valid`: with no nibble pending, store it as the high nibble. With one pending, form {hi, dout} into the output register.
  - If the output register is still full and not accepted that cycle, set `overflow_err`, drop the new byte and keep the held byte.
  - `demod_packet_detected` falling → FLUSH. A nibble arriving in the same cycle is packed first.
- FLUSH
  - A pending nibble is emitted as {hi, 4'h0} and `odd_nibble` is set. If the output register is busy, wait for it.
  - Once the register is empty or accepted → DONE.
- DONE: `pkt_done`=1 for one cycle, then IDLE. IDLE restarts immediately if `enable` is still high.
- `enable`=0 in any non-IDLE state: go to IDLE next cycle, clearing `byte_valid`, the pending nibble and the timer. `pkt_done` is not pulsed.
- Threshold, retry and timer arithmetic is unsigned. The timer saturates and never wraps.

## Timing
- Reset values
  - Outputs: `demod_resetn`=0, `demod_rx_start`=0, `demod_corr_threshold`=0, `byte_valid`=0, `byte_data`=0, `busy`=0, `pkt_done`=0, all flags 0.
  - Internal: state = IDLE.
- All outputs are registered.
- Latency, `enable` rising to `demod_rx_start`: cycle+1 enters RST_DEMOD, `demod_rx_start` is high at cycle+3.
- Second nibble `demod_dout_valid` → `byte_valid` high on the next cycle.
- `byte_data` is stable while `byte_valid` && !`byte_ready`.
- A new byte may be loaded in the same cycle the held one is accepted, so there is no bubble.
- `demod_corr_threshold` changes only while `demod_resetn`=0.

## Structure
- Package `ppm16_rx_pkg` holds:
  - the state enum;
  - RESET_CYCLES=2;
  - a threshold-step function (saturating decrement to the floor).
- Sub-module `ppm16_nibble_packer` holds the pending nibble, the output register, valid/ready logic, the flush-with-zero path and overflow detection.
- The FSM, timer, retry counter and threshold register stay at top level.

## Test plan
- Normal packet: `enable`=1, `cfg_threshold`=2, a demod model detects at cycle 20 and emits nibbles 1,2,3,4 → bytes 0x12, 0x34, one `pkt_done`, all flags 0.
- Retry and step: `cfg_search_timeout`=50, `cfg_max_retries`=2, `cfg_threshold`=3, `cfg_min_threshold`=2, no detection.
  - Expect 3 `demod_rx_start` pulses with thresholds 3, 2, 2.
  - Then `timeout_err`=1 and `pkt_done`.
- Odd nibble: nibbles 0xA,0xB,0xC, then detection drops → bytes 0xAB, 0xC0, `odd_nibble`=1.
- Backpressure: `byte_ready`=0 throughout 4 nibbles 5,6,7,8 → 0x56 held, `overflow_err`=1, 0x78 dropped. Raising `byte_ready` releases 0x56, then `pkt_done`.
- Abort and reset: `enable`=0 mid-RECEIVE → IDLE next cycle, `byte_valid`=0, no `pkt_done`. `reset`=1 mid-SEARCH → all outputs at reset values next cycle.

Source files
------------

// File: rtl/ppm16_rx_pkg.sv
// Shared types and helpers for the PPM16 receive-session controller.
package ppm16_rx_pkg;

    // state       | meaning
    // S_IDLE      | demod held in reset, waiting for enable
    // S_RST_DEMOD | demod reset pulse, RESET_CYCLES long
    // S_ARM       | one-cycle rx_start to demod, search timer cleared
    // S_SEARCH    | waiting for packet detect, timeout triggers retry
    // S_RECEIVE   | packing demod nibbles into bytes
    // S_FLUSH     | emitting a leftover nibble, draining the output byte
    // S_DONE      | one-cycle pkt_done
    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_DEMOD,
        S_ARM,
        S_SEARCH,
        S_RECEIVE,
        S_FLUSH,
        S_DONE
    } rx_state_t;

    localparam int RESET_CYCLES  = 2;
    localparam int RST_CNT_BITS  = 2;
    localparam int THR_CALC_BITS = 8;

    function automatic logic [THR_CALC_BITS-1:0] thr_step(
        input logic [THR_CALC_BITS-1:0] thr,
        input logic [THR_CALC_BITS-1:0] min_thr
    );
        return (thr > min_thr) ? thr - 1'b1 : min_thr;
    endfunction

endpackage

// File: rtl/ppm16_nibble_packer.sv
// Packs 4-bit demod symbols into bytes behind a one-entry valid/ready register.
module ppm16_nibble_packer (
    input  logic       clk,
    input  logic       reset,
    input  logic       abort,
    input  logic       clear,
    input  logic       nib_valid,
    input  logic [3:0] nib,
    input  logic       flush,
    input  logic       byte_ready,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       overflow_err,
    output logic       odd_nibble,
    output logic       drained
);

    logic [3:0] hi;
    logic       pend;
    logic       room;

    // The held byte leaving this cycle frees the register for a same-cycle load.
    assign room    = !byte_valid || byte_ready;
    assign drained = !pend && room;

    always_ff @(posedge clk) begin
        if (reset) begin
            hi           <= '0;
            pend         <= 1'b0;
            byte_valid   <= 1'b0;
            byte_data    <= '0;
            overflow_err <= 1'b0;
            odd_nibble   <= 1'b0;
        end else if (abort) begin
            pend       <= 1'b0;
            byte_valid <= 1'b0;
        end else begin
            if (clear) begin
                overflow_err <= 1'b0;
                odd_nibble   <= 1'b0;
            end
            if (byte_valid && byte_ready) begin
                byte_valid <= 1'b0;
            end
            if (nib_valid) begin
                if (!pend) begin
                    hi   <= nib;
                    pend <= 1'b1;
                end else begin
                    pend <= 1'b0;
                    if (room) begin
                        byte_data  <= {hi, nib};
                        byte_valid <= 1'b1;
                    end else begin
                        overflow_err <= 1'b1;
                    end
                end
            end else if (flush && pend && room) begin
                byte_data  <= {hi, 4'h0};
                byte_valid <= 1'b1;
                pend       <= 1'b0;
                odd_nibble <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ppm16_rx_ctrl.sv
// Receive-session sequencer for ppm16_demod: reset/arm/search with threshold-stepping retries.
module ppm16_rx_ctrl
    import ppm16_rx_pkg::*;
#(
    parameter int CHIP_BITS    = 2,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [CHIP_BITS-1:0]    cfg_threshold,
    input  logic [CHIP_BITS-1:0]    cfg_min_threshold,
    input  logic [TIMEOUT_BITS-1:0] cfg_search_timeout,
    input  logic [3:0]              cfg_max_retries,
    output logic                    demod_resetn,
    output logic                    demod_rx_start,
    output logic [CHIP_BITS-1:0]    demod_corr_threshold,
    input  logic                    demod_packet_detected,
    input  logic                    demod_dout_valid,
    input  logic [3:0]              demod_dout,
    output logic                    byte_valid,
    output logic [7:0]              byte_data,
    input  logic                    byte_ready,
    output logic                    busy,
    output logic                    pkt_done,
    output logic                    timeout_err,
    output logic                    overflow_err,
    output logic                    odd_nibble
);

    rx_state_t               state;
    logic [RST_CNT_BITS-1:0] rst_cnt;
    logic [TIMEOUT_BITS-1:0] timer;
    logic [3:0]              retries;

    logic abort;
    logic clear;
    logic nib_valid;
    logic flush;
    logic drained;
    logic timeout_hit;

    assign abort       = (state != S_IDLE) && !enable;
    assign clear       = (state == S_IDLE) && enable;
    assign nib_valid   = (state == S_RECEIVE) && demod_dout_valid;
    assign flush       = (state == S_FLUSH);
    assign timeout_hit = (cfg_search_timeout != '0) && (timer == cfg_search_timeout);

    ppm16_nibble_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .abort        (abort),
        .clear        (clear),
        .nib_valid    (nib_valid),
        .nib          (demod_dout),
        .flush        (flush),
        .byte_ready   (byte_ready),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .overflow_err (overflow_err),
        .odd_nibble   (odd_nibble),
        .drained      (drained)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= S_IDLE;
            rst_cnt              <= '0;
            timer                <= '0;
            retries              <= '0;
            demod_resetn         <= 1'b0;
            demod_rx_start       <= 1'b0;
            demod_corr_threshold <= '0;
            busy                 <= 1'b0;
            pkt_done             <= 1'b0;
            timeout_err          <= 1'b0;
        end else begin
            demod_rx_start <= 1'b0;
            pkt_done       <= 1'b0;
            if (abort) begin
                state        <= S_IDLE;
                timer        <= '0;
                demod_resetn <= 1'b0;
                busy         <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (enable) begin
                            demod_corr_threshold <= cfg_threshold;
                            retries              <= '0;
                            timeout_err          <= 1'b0;
                            rst_cnt              <= '0;
                            busy                 <= 1'b1;
                            state                <= S_RST_DEMOD;
                        end
                    end
                    S_RST_DEMOD: begin
                        if (rst_cnt == RST_CNT_BITS'(RESET_CYCLES - 1)) begin
                            demod_resetn   <= 1'b1;
                            demod_rx_start <= 1'b1;
                            state          <= S_ARM;
                        end else begin
                            rst_cnt <= rst_cnt + 1'b1;
                        end
                    end
                    S_ARM: begin
                        timer <= '0;
                        state <= S_SEARCH;
                    end
                    S_SEARCH: begin
                        if (demod_packet_detected) begin
                            state <= S_RECEIVE;
                        end else if (timeout_hit) begin
                            if (retries < cfg_max_retries) begin
                                retries              <= retries + 1'b1;
                                demod_corr_threshold <= CHIP_BITS'(thr_step(
                                    THR_CALC_BITS'(demod_corr_threshold),
                                    THR_CALC_BITS'(cfg_min_threshold)));
                                demod_resetn         <= 1'b0;
                                rst_cnt              <= '0;
                                state                <= S_RST_DEMOD;
                            end else begin
                                timeout_err <= 1'b1;
                                pkt_done    <= 1'b1;
                                state       <= S_DONE;
                            end
                        end else if (timer != '1) begin
                            timer <= timer + 1'b1;
                        end
                    end
                    S_RECEIVE: begin
                        if (!demod_packet_detected) begin
                            state <= S_FLUSH;
                        end
                    end
                    S_FLUSH: begin
                        if (drained) begin
                            pkt_done <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        demod_resetn <= 1'b0;
                        busy         <= 1'b0;
                        state        <= S_IDLE;
                    end
                    default: begin
                        demod_resetn <= 1'b0;
                        busy         <= 1'b0;
                        state        <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
